// File: rtl/chirp_seq_pkg.sv
// Shared types and constants for the chirp burst sequencer.
package chirp_seq_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_INIT,
      S_WAIT_READY,
      S_ARM,
      S_CHIRP,
      S_POST,
      S_GAP,
      S_DONE
   } seq_state_t;

   localparam int TIMEOUT_CYCLES_DEF = 4096;
   localparam int CNT_WIDTH_DEF      = 32;
   localparam int PULSE_W            = 16;
   localparam int WIN_W              = 16;

endpackage

// File: rtl/chirp_burst_sequencer_counter.sv
// Loadable down-counter with zero flag; holds at zero.
module seq_down_counter #(
   parameter int W = 16
) (
   input  logic         clk_245,
   input  logic         clk_245_rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] count;

   always_ff @(posedge clk_245) begin
      if (clk_245_rst)
         count <= '0;
      else if (load)
         count <= load_val;
      else if (dec && count != '0)
         count <= count - 1'b1;
   end

   assign zero = (count == '0);

endmodule

// File: rtl/chirp_burst_sequencer.sv
// Burst sequencer driving chirp DDS init/enable and the ADC capture gate.
module chirp_burst_sequencer
   import chirp_seq_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
   parameter int CNT_WIDTH      = CNT_WIDTH_DEF
) (
   input  logic                 clk_245,
   input  logic                 clk_245_rst,
   input  logic                 seq_start,
   input  logic                 seq_abort,
   input  logic [PULSE_W-1:0]   pulse_count_max,
   input  logic [CNT_WIDTH-1:0] pri_cycles,
   input  logic [WIN_W-1:0]     pre_capture_cycles,
   input  logic [WIN_W-1:0]     post_capture_cycles,
   input  logic                 chirp_ready,
   input  logic                 chirp_done,
   input  logic                 chirp_active,
   input  logic                 adc_fifo_almost_full,
   output logic                 chirp_init,
   output logic                 chirp_enable,
   output logic                 adc_enable,
   output logic                 seq_busy,
   output logic                 seq_done,
   output logic [PULSE_W-1:0]   pulse_index,
   output logic                 err_timeout,
   output logic                 err_overrun
);

   localparam int TO_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYCLES - 1);

   seq_state_t state, state_nxt;
   logic [CNT_WIDTH-1:0] pri_cnt;
   logic clr, idx_inc, timeout, ovr_hit;
   logic win_zero, to_zero, st_chg;
   logic [WIN_W-1:0] win_val;

   assign st_chg  = (state_nxt != state);
   assign win_val = (state_nxt == S_POST) ? post_capture_cycles - 1'b1
                                          : pre_capture_cycles - 1'b1;

   seq_down_counter #(.W(WIN_W)) u_win (
      .clk_245     (clk_245),
      .clk_245_rst (clk_245_rst),
      .load        (st_chg),
      .load_val    (win_val),
      .dec         (state == S_ARM || state == S_POST),
      .zero        (win_zero)
   );

   seq_down_counter #(.W(TO_W)) u_to (
      .clk_245     (clk_245),
      .clk_245_rst (clk_245_rst),
      .load        (st_chg),
      .load_val    (TO_LOAD),
      .dec         (state == S_WAIT_READY || state == S_CHIRP),
      .zero        (to_zero)
   );

   always_comb begin
      state_nxt = state;
      clr       = 1'b0;
      idx_inc   = 1'b0;
      timeout   = 1'b0;
      unique case (state)
         S_IDLE: if (seq_start) begin
            state_nxt = S_INIT;
            clr       = 1'b1;
         end
         S_INIT: state_nxt = S_WAIT_READY;
         S_WAIT_READY: begin
            if (chirp_ready)
               state_nxt = (pre_capture_cycles == '0) ? S_CHIRP : S_ARM;
            else if (to_zero) begin
               state_nxt = S_IDLE;
               timeout   = 1'b1;
            end
         end
         S_ARM: if (win_zero) state_nxt = S_CHIRP;
         S_CHIRP: begin
            if (chirp_done) begin
               if (post_capture_cycles == '0) begin
                  state_nxt = S_GAP;
                  idx_inc   = 1'b1;
               end else
                  state_nxt = S_POST;
            end else if (to_zero) begin
               state_nxt = S_IDLE;
               timeout   = 1'b1;
            end
         end
         S_POST: if (win_zero) begin
            state_nxt = S_GAP;
            idx_inc   = 1'b1;
         end
         S_GAP: begin
            if (pri_cnt >= pri_cycles && !adc_fifo_almost_full)
               state_nxt = (pulse_count_max != '0 &&
                            pulse_index == pulse_count_max) ? S_DONE : S_INIT;
         end
         S_DONE: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
      // Abort outranks start, timeout and index update alike
      if (seq_abort) begin
         state_nxt = S_IDLE;
         clr       = 1'b0;
         idx_inc   = 1'b0;
         timeout   = 1'b0;
      end
   end

   assign ovr_hit = !seq_abort && pri_cnt >= pri_cycles &&
                    (state inside {S_INIT, S_WAIT_READY, S_ARM, S_CHIRP, S_POST});

   always_ff @(posedge clk_245) begin
      if (clk_245_rst) begin
         state        <= S_IDLE;
         pri_cnt      <= '0;
         chirp_init   <= 1'b0;
         chirp_enable <= 1'b0;
         adc_enable   <= 1'b0;
         seq_busy     <= 1'b0;
         seq_done     <= 1'b0;
         pulse_index  <= '0;
         err_timeout  <= 1'b0;
         err_overrun  <= 1'b0;
      end else begin
         state        <= state_nxt;
         chirp_init   <= (state_nxt == S_INIT);
         chirp_enable <= (state_nxt == S_CHIRP);
         adc_enable   <= (state_nxt inside {S_ARM, S_CHIRP, S_POST});
         seq_busy     <= (state_nxt != S_IDLE);
         seq_done     <= (state_nxt == S_DONE);
         if (state_nxt == S_INIT)
            pri_cnt <= CNT_WIDTH'(1);
         else if (state != S_IDLE && pri_cnt != '1)
            pri_cnt <= pri_cnt + 1'b1;
         if (clr) begin
            pulse_index <= '0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
         end else begin
            if (idx_inc) pulse_index <= pulse_index + 1'b1;
            if (timeout) err_timeout <= 1'b1;
            if (ovr_hit) err_overrun <= 1'b1;
         end
      end
   end

   a_en_adc: assert property (@(posedge clk_245) disable iff (clk_245_rst)
      chirp_enable |-> adc_enable);
   a_init_1c: assert property (@(posedge clk_245) disable iff (clk_245_rst)
      chirp_init |=> !chirp_init);
   a_active: assert property (@(posedge clk_245) disable iff (clk_245_rst)
      chirp_active |-> seq_busy);

endmodule

// File: tb/tb_chirp_burst_sequencer.sv
// Directed bench for chirp_burst_sequencer with a simple DDS responder.
module tb_chirp_burst_sequencer;

   logic        clk_245 = 1'b0;
   logic        clk_245_rst = 1'b0;
   logic        seq_start = 1'b0;
   logic        seq_abort = 1'b0;
   logic [15:0] pulse_count_max = '0;
   logic [31:0] pri_cycles = '0;
   logic [15:0] pre_capture_cycles = '0;
   logic [15:0] post_capture_cycles = '0;
   logic        chirp_ready = 1'b0;
   logic        chirp_done = 1'b0;
   logic        chirp_active;
   logic        adc_fifo_almost_full = 1'b0;
   logic        chirp_init, chirp_enable, adc_enable;
   logic        seq_busy, seq_done, err_timeout, err_overrun;
   logic [15:0] pulse_index;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int init_q[$];
   int adc_cnt, en_cnt, done_cnt, first_adc, first_en, en_run;
   int done_len = 50;

   assign chirp_active = chirp_enable;

   always #2 clk_245 = ~clk_245;

   chirp_burst_sequencer dut (
      .clk_245              (clk_245),
      .clk_245_rst          (clk_245_rst),
      .seq_start            (seq_start),
      .seq_abort            (seq_abort),
      .pulse_count_max      (pulse_count_max),
      .pri_cycles           (pri_cycles),
      .pre_capture_cycles   (pre_capture_cycles),
      .post_capture_cycles  (post_capture_cycles),
      .chirp_ready          (chirp_ready),
      .chirp_done           (chirp_done),
      .chirp_active         (chirp_active),
      .adc_fifo_almost_full (adc_fifo_almost_full),
      .chirp_init           (chirp_init),
      .chirp_enable         (chirp_enable),
      .adc_enable           (adc_enable),
      .seq_busy             (seq_busy),
      .seq_done             (seq_done),
      .pulse_index          (pulse_index),
      .err_timeout          (err_timeout),
      .err_overrun          (err_overrun)
   );

   task automatic step();
      @(posedge clk_245);
      #1;
      cyc++;
      if (chirp_init) init_q.push_back(cyc);
      adc_cnt += int'(adc_enable);
      en_cnt  += int'(chirp_enable);
      if (seq_done) done_cnt++;
      if (adc_enable && first_adc < 0) first_adc = cyc;
      if (chirp_enable && first_en < 0) first_en = cyc;
      en_run = chirp_enable ? en_run + 1 : 0;
      chirp_done = chirp_enable && (en_run == done_len + 1);
   endtask

   task automatic clr_mon();
      init_q.delete();
      adc_cnt = 0; en_cnt = 0; done_cnt = 0;
      first_adc = -1; first_en = -1; en_run = 0;
   endtask

   task automatic cfg(input int mx, input int p, input int q, input int pri);
      pulse_count_max     = 16'(mx);
      pre_capture_cycles  = 16'(p);
      post_capture_cycles = 16'(q);
      pri_cycles          = 32'(pri);
   endtask

   task automatic start();
      seq_start = 1'b1;
      step();
      seq_start = 1'b0;
   endtask

   task automatic run_idle(input int budget);
      for (int i = 0; i < budget && seq_busy; i++) step();
   endtask

   task automatic test_reset();
      clk_245_rst = 1'b1;
      repeat (3) step();
      clk_245_rst = 1'b0;
      step();
      checks++;
      if ({chirp_init, chirp_enable, adc_enable, seq_busy, seq_done} !== 5'b0) begin
         $display("FAIL reset_ctl got %b exp 00000",
                  {chirp_init, chirp_enable, adc_enable, seq_busy, seq_done});
         errors++;
      end
      checks++;
      if ({pulse_index, err_timeout, err_overrun} !== 18'd0) begin
         $display("FAIL reset_stat idx %0d to %b ov %b exp 0",
                  pulse_index, err_timeout, err_overrun);
         errors++;
      end
   endtask

   task automatic test_single_chirp();
      cfg(1, 4, 8, 100);
      chirp_ready = 1'b1;
      clr_mon();
      start();
      checks++;
      if (chirp_init !== 1'b1 || seq_busy !== 1'b1) begin
         $display("FAIL init_latency init %b busy %b exp 1 1", chirp_init, seq_busy);
         errors++;
      end
      step();
      checks++;
      if (chirp_init !== 1'b0) begin
         $display("FAIL init_width got %b exp 0", chirp_init);
         errors++;
      end
      run_idle(1000);
      checks++;
      if (seq_busy !== 1'b0) begin
         $display("FAIL single_idle busy %b exp 0", seq_busy);
         errors++;
      end
      checks++;
      if (adc_cnt != 63) begin
         $display("FAIL single_adc got %0d exp 63", adc_cnt);
         errors++;
      end
      checks++;
      if (en_cnt != 51) begin
         $display("FAIL single_en got %0d exp 51", en_cnt);
         errors++;
      end
      checks++;
      if (first_en - first_adc != 4) begin
         $display("FAIL single_lead got %0d exp 4", first_en - first_adc);
         errors++;
      end
      checks++;
      if (done_cnt != 1 || pulse_index !== 16'd1) begin
         $display("FAIL single_done done %0d idx %0d exp 1 1", done_cnt, pulse_index);
         errors++;
      end
      checks++;
      if (init_q.size() != 1 || err_overrun !== 1'b0) begin
         $display("FAIL single_misc inits %0d ov %b exp 1 0", init_q.size(), err_overrun);
         errors++;
      end
   endtask

   task automatic test_overrun();
      cfg(2, 4, 8, 20);
      clr_mon();
      start();
      run_idle(1000);
      checks++;
      if (err_overrun !== 1'b1) begin
         $display("FAIL ovr_flag got %b exp 1", err_overrun);
         errors++;
      end
      checks++;
      if (init_q.size() != 2 || init_q[1] - init_q[0] != 66) begin
         $display("FAIL ovr_spacing n %0d got %0d exp 66",
                  init_q.size(), init_q[1] - init_q[0]);
         errors++;
      end
      checks++;
      if (done_cnt != 1 || pulse_index !== 16'd2 || seq_busy !== 1'b0) begin
         $display("FAIL ovr_done done %0d idx %0d busy %b exp 1 2 0",
                  done_cnt, pulse_index, seq_busy);
         errors++;
      end
   endtask

   task automatic test_burst();
      cfg(3, 4, 8, 200);
      clr_mon();
      start();
      run_idle(2000);
      checks++;
      if (init_q.size() != 3) begin
         $display("FAIL burst_inits got %0d exp 3", init_q.size());
         errors++;
      end
      checks++;
      if (init_q[1] - init_q[0] != 200 || init_q[2] - init_q[1] != 200) begin
         $display("FAIL burst_pri got %0d %0d exp 200 200",
                  init_q[1] - init_q[0], init_q[2] - init_q[1]);
         errors++;
      end
      checks++;
      if (done_cnt != 1 || pulse_index !== 16'd3 || err_overrun !== 1'b0) begin
         $display("FAIL burst_end done %0d idx %0d ov %b exp 1 3 0",
                  done_cnt, pulse_index, err_overrun);
         errors++;
      end
   endtask

   task automatic test_timeout();
      int n;
      cfg(1, 4, 8, 100);
      chirp_ready = 1'b0;
      clr_mon();
      start();
      n = 0;
      while (!err_timeout && n < 5000) begin
         step();
         n++;
      end
      checks++;
      if (n != 4097) begin
         $display("FAIL timeout_cycles got %0d exp 4097", n);
         errors++;
      end
      checks++;
      if (seq_busy !== 1'b0 || done_cnt != 0 || adc_cnt != 0) begin
         $display("FAIL timeout_state busy %b done %0d adc %0d exp 0 0 0",
                  seq_busy, done_cnt, adc_cnt);
         errors++;
      end
      chirp_ready = 1'b1;
   endtask

   task automatic test_backpressure();
      cfg(2, 4, 8, 100);
      clr_mon();
      start();
      adc_fifo_almost_full = 1'b1;
      for (int k = 1; k <= 149; k++) step();
      adc_fifo_almost_full = 1'b0;
      checks++;
      if (err_timeout !== 1'b0) begin
         $display("FAIL bp_to_clear got %b exp 0", err_timeout);
         errors++;
      end
      run_idle(1000);
      checks++;
      if (init_q.size() != 2 || init_q[1] - init_q[0] != 150) begin
         $display("FAIL bp_spacing n %0d got %0d exp 150",
                  init_q.size(), init_q[1] - init_q[0]);
         errors++;
      end
      checks++;
      if (done_cnt != 1 || pulse_index !== 16'd2 || err_overrun !== 1'b0) begin
         $display("FAIL bp_end done %0d idx %0d ov %b exp 1 2 0",
                  done_cnt, pulse_index, err_overrun);
         errors++;
      end
   endtask

   task automatic test_abort();
      cfg(0, 4, 8, 20);
      clr_mon();
      start();
      for (int i = 0; i < 200 && en_run < 20; i++) step();
      checks++;
      if (err_overrun !== 1'b1 || chirp_enable !== 1'b1) begin
         $display("FAIL abort_pre ov %b en %b exp 1 1", err_overrun, chirp_enable);
         errors++;
      end
      seq_start = 1'b1;
      step();
      seq_start = 1'b0;
      checks++;
      if (chirp_init !== 1'b0 || chirp_enable !== 1'b1 || err_overrun !== 1'b1) begin
         $display("FAIL busy_start init %b en %b ov %b exp 0 1 1",
                  chirp_init, chirp_enable, err_overrun);
         errors++;
      end
      seq_abort = 1'b1;
      step();
      seq_abort = 1'b0;
      checks++;
      if ({chirp_init, chirp_enable, adc_enable, seq_busy, seq_done} !== 5'b0) begin
         $display("FAIL abort_out got %b exp 00000",
                  {chirp_init, chirp_enable, adc_enable, seq_busy, seq_done});
         errors++;
      end
      checks++;
      if (err_overrun !== 1'b1 || pulse_index !== 16'd0 || done_cnt != 0) begin
         $display("FAIL abort_stat ov %b idx %0d done %0d exp 1 0 0",
                  err_overrun, pulse_index, done_cnt);
         errors++;
      end
      step();
      checks++;
      if (seq_busy !== 1'b0) begin
         $display("FAIL abort_idle busy %b exp 0", seq_busy);
         errors++;
      end
   endtask

   task automatic test_reset_mid_arm();
      cfg(1, 4, 8, 2);
      clr_mon();
      start();
      for (int i = 0; i < 20 && !(adc_enable && !chirp_enable); i++) step();
      checks++;
      if (adc_enable !== 1'b1 || err_overrun !== 1'b1) begin
         $display("FAIL arm_pre adc %b ov %b exp 1 1", adc_enable, err_overrun);
         errors++;
      end
      step();
      clk_245_rst = 1'b1;
      step();
      clk_245_rst = 1'b0;
      checks++;
      if ({chirp_init, chirp_enable, adc_enable, seq_busy, seq_done} !== 5'b0) begin
         $display("FAIL rst_arm_out got %b exp 00000",
                  {chirp_init, chirp_enable, adc_enable, seq_busy, seq_done});
         errors++;
      end
      checks++;
      if (err_overrun !== 1'b0 || err_timeout !== 1'b0 || done_cnt != 0) begin
         $display("FAIL rst_arm_err ov %b to %b done %0d exp 0 0 0",
                  err_overrun, err_timeout, done_cnt);
         errors++;
      end
      step();
      checks++;
      if (seq_busy !== 1'b0 || adc_enable !== 1'b0) begin
         $display("FAIL rst_arm_idle busy %b adc %b exp 0 0", seq_busy, adc_enable);
         errors++;
      end
   endtask

   initial begin
      clr_mon();
      test_reset();
      test_single_chirp();
      test_overrun();
      test_burst();
      test_timeout();
      test_backpressure();
      test_abort();
      test_reset_mid_arm();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
